seg_scan_master: RTL and testbench
==================================

SEG_SCAN_MASTER -- requirements
Module: seg_scan_master

Interface
- REQ-001: Parameter CLK_DIV, default 2, SHALL set the sck half-period in clk cycles (legal values ≥1).
- REQ-002: Parameter HOLD_CYCLES, default 64, SHALL set the en-low display/hold time per frame in clk cycles (legal values ≥4).
- REQ-003: Parameter SAMPLE_AT, default 8, SHALL set the hold-phase cycle index at which miso is sampled (legal range 3 ≤ SAMPLE_AT < HOLD_CYCLES).
- REQ-004: Port clk, input, 1 bit, SHALL be the single clock; every flop is clocked on its rising edge.
- REQ-005: Port rst, input, 1 bit, SHALL be a synchronous, active-high reset.
- REQ-006: Port run, input, 1 bit, SHALL enable continuous frame generation.
- REQ-007: Port digits, input, 16 bits, SHALL carry the hex value for screen n on digits[4n+3:4n].
- REQ-008: Port miso, input, 1 bit, SHALL be the decoder MISO line, asynchronous to clk.
- REQ-009: Port sck, output, 1 bit, SHALL be the decoder SPI clock.
- REQ-010: Port mosi, output, 1 bit, SHALL be the decoder SPI data, sent MSB first.
- REQ-011: Port en, output, 1 bit, SHALL be the decoder enable; high during shift, and its falling edge latches the frame.
- REQ-012: Port spi_reset_n, output, 1 bit, SHALL drive the decoder RESET input.
- REQ-013: Port key_state, output, 16 bits, SHALL give the pressed state for key index plxr*4+screen (1 = pressed).
- REQ-014: Port key_valid, output, 1 bit, SHALL be a one-cycle pulse marking a completed 16-frame key sweep.

Function
- REQ-015: The FSM SHALL have the states IDLE, SHIFT, TAIL and HOLD.
- REQ-016: A 4-bit frame counter f SHALL set the frame fields: screen = f[1:0], plxr = f[3:2].
- REQ-017: The frame byte SHALL be {plxr[1:0], screen[1:0], digits[4*screen+3 -: 4]}, with digits captured when the frame starts.
- REQ-018: In IDLE with run=1, the next cycle (frame cycle 0) SHALL set en=1, sck=0, mosi=byte[7] and enter SHIFT.
- REQ-019: sck SHALL rise at frame cycle (2k+1)*CLK_DIV and fall at (2k+2)*CLK_DIV, for k = 0..7.
- REQ-020: mosi SHALL change to byte[6-k] only on the sck fall of bit k, so it is stable across every rising edge.
- REQ-021: After the 8th sck fall (frame cycle 16*CLK_DIV), the FSM SHALL enter TAIL with sck=0.
- REQ-022: en SHALL fall at frame cycle 17*CLK_DIV, and the FSM SHALL then enter HOLD.
- REQ-023: HOLD SHALL last exactly HOLD_CYCLES cycles with en=0 and sck=0, giving a frame period of 17*CLK_DIV + HOLD_CYCLES (98 cycles at defaults).
- REQ-024: miso SHALL pass through a 2-flop synchronizer.
- REQ-025: At HOLD cycle SAMPLE_AT, key_state[plxr*4+screen] SHALL be loaded with the inverted synchronized miso.
- REQ-026: At the end of HOLD, f SHALL increment modulo 16.
- REQ-027: When f wraps from 15 to 0, key_valid SHALL pulse for one cycle, coincident with the final HOLD cycle.
- REQ-028: At the end of HOLD, the FSM SHALL start the next frame directly if run=1, otherwise it SHALL go to IDLE.
- REQ-029: Deasserting run mid-frame SHALL NOT truncate the frame; the frame completes, including HOLD and sampling.
- REQ-030: Changes to digits mid-frame SHALL NOT affect the current frame.
- REQ-031: key_state SHALL hold its value while in IDLE.
- REQ-032: When run is reasserted, operation SHALL resume at the current f.

Reset
- REQ-033: While rst=1, the block SHALL drive state=IDLE, f=0, sck=0, mosi=0, en=0, key_state=0 and key_valid=0.
- REQ-034: While rst=1, spi_reset_n SHALL be 0 (registered); it SHALL go to 1 on the first clk edge with rst=0.
- REQ-035: rst asserted mid-frame SHALL take effect on the next edge: en=0, sck=0, spi_reset_n=0, and the partial frame is discarded with no key_state update.
- REQ-036: rst SHALL take priority over run.

Verification
- REQ-037: Defaults, digits=16'h4321, run=1 from reset, decoder model attached -> first four frames shift bytes 0x01, 0x12, 0x23, 0x34; each has exactly 8 sck rising edges, en high for 34 cycles, and a 98-cycle frame period.
- REQ-038: Model with key at plxr=2, screen=1 pressed (miso low while that frame is latched) -> after sweep, key_valid pulses once and key_state=16'h0200.
- REQ-039: run dropped at SHIFT cycle 5 -> frame completes (en falls at cycle 34, HOLD of 64 cycles), then IDLE with sck=0 and en=0; run reasserted -> next frame uses f+1.
- REQ-040: digits changed from 16'h4321 to 16'hFFFF at SHIFT cycle 3 of frame f=0 -> that frame still shifts 0x01, and frame f=1 shifts 0x1F.
- REQ-041: rst pulsed at HOLD cycle 2 -> next cycle en=0, spi_reset_n=0, key_state=0, f=0; restart begins with byte 0x01.
- REQ-042: CLK_DIV=1, HOLD_CYCLES=4, SAMPLE_AT=3 -> frame period of 21 cycles; miso toggling 1 cycle before the sample point is not captured, while a miso level held ≥3 cycles before the sample point is.

Source files
------------

// File: rtl/seg_scan_master.sv
// seg_scan_master: scans four hex screens and a 4x4 key matrix through an SPI-style decoder,
// one 8-bit frame per digit/key position, 16 frames per full key sweep.
module seg_scan_master #(
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 64,
    parameter int SAMPLE_AT   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] digits,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        en,
    output logic        spi_reset_n,
    output logic [15:0] key_state,
    output logic        key_valid
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int HW = $clog2(HOLD_CYCLES);
    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, HOLD} state_t;
    state_t state;
    logic [3:0] f, fn;
    logic [DW-1:0] dv;
    logic [2:0] bits;
    logic [HW-1:0] hc;
    logic [7:0] sh, frame_byte;
    logic m1, m2, div_end, hold_end, go;
    always_comb begin
        div_end = dv == DW'(CLK_DIV - 1);
        hold_end = hc == HW'(HOLD_CYCLES - 1);
        fn = state == HOLD ? f + 4'd1 : f;
        go = run && (state == IDLE || (state == HOLD && hold_end));
        frame_byte = {fn, digits[{fn[1:0], 2'b00} +: 4]};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f <= '0;
            dv <= '0;
            bits <= '0;
            hc <= '0;
            sh <= '0;
            sck <= 1'b0;
            mosi <= 1'b0;
            en <= 1'b0;
            spi_reset_n <= 1'b0;
            key_state <= '0;
            key_valid <= 1'b0;
            m1 <= 1'b0;
            m2 <= 1'b0;
        end else begin
            m1 <= miso;
            m2 <= m1;
            spi_reset_n <= 1'b1;
            key_valid <= 1'b0;
            dv <= div_end ? '0 : dv + 1'b1;
            case (state)
                SHIFT: if (div_end) begin
                    sck <= ~sck;
                    // data only moves on the falling edge so it is stable for the decoder's rising edge
                    if (sck) begin
                        sh <= sh << 1;
                        mosi <= sh[6];
                        bits <= bits + 3'd1;
                        if (bits == 3'd7) state <= TAIL;
                    end
                end
                TAIL: if (div_end) begin
                    en <= 1'b0;
                    hc <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    hc <= hc + 1'b1;
                    if (hc == HW'(SAMPLE_AT)) key_state[f] <= ~m2;
                    if (hc == HW'(HOLD_CYCLES - 2) && f == 4'hF) key_valid <= 1'b1;
                    if (hold_end) begin
                        f <= f + 4'd1;
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
            if (go) begin
                state <= SHIFT;
                en <= 1'b1;
                sck <= 1'b0;
                dv <= '0;
                bits <= '0;
                sh <= frame_byte;
                mosi <= frame_byte[7];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_master.sv
// tb_seg_scan_master: directed sequence with randomized digits/keys, checked against
// a decoder/key-matrix model that reconstructs frames from the sck/mosi/en pins.
module tb_seg_scan_master;
    logic clk = 0, rst = 1, run = 0, run2 = 0, miso, miso2 = 1;
    logic [15:0] digits = 16'h4321, pressed = 16'h0200;
    logic sck, mosi, en, spi_reset_n, key_valid, sck2, mosi2, en2, srn2, kv2;
    logic [15:0] key_state, ks2;

    seg_scan_master dut (
        .clk(clk), .rst(rst), .run(run), .digits(digits), .miso(miso),
        .sck(sck), .mosi(mosi), .en(en), .spi_reset_n(spi_reset_n),
        .key_state(key_state), .key_valid(key_valid)
    );
    seg_scan_master #(.CLK_DIV(1), .HOLD_CYCLES(4), .SAMPLE_AT(3)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .digits(digits), .miso(miso2),
        .sck(sck2), .mosi(mosi2), .en(en2), .spi_reset_n(srn2),
        .key_state(ks2), .key_valid(kv2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        int          rises, enhi, start, f;
        logic [15:0] dig;
    } frame_t;
    frame_t q[$];
    frame_t cur;
    int cyc = 0, nf = 0, fc = 0, hcy = 0, kvn = 0, cmp = 0, errs = 0, last_start = 0;
    int st2 = 0, fc2 = 0, ls2 = 0, per2 = 0, eh2 = 0, ehc2 = 0;
    logic pe = 0, ps = 0, pe2 = 0;
    logic [7:0] shr = 0;
    logic [3:0] lidx = 0;

    // key matrix: the decoder pulls miso low when the latched frame's key is pressed
    assign miso = ~pressed[lidx];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            nf = 0; fc = 0; hcy = 0; st2 = 0; fc2 = 0; lidx = 0;
        end else begin
            if (en && !pe) begin
                cur.start = cyc; cur.dig = digits; cur.f = nf; nf = (nf + 1) % 16;
                cur.rises = 0; cur.enhi = 0; shr = 0; fc = 0;
            end else fc++;
            if (en) cur.enhi++;
            if (en && sck && !ps) begin cur.rises++; shr = {shr[6:0], mosi}; end
            if (!en && pe) begin cur.b = shr; q.push_back(cur); lidx = shr[7:4]; hcy = 0; end
            else hcy++;
            if (key_valid) kvn++;
            if (en2 && !pe2) begin
                if (st2 > 0) per2 = cyc - ls2;
                ls2 = cyc; st2++; fc2 = 0; ehc2 = 0;
            end else fc2++;
            if (en2) ehc2++;
            if (!en2 && pe2) eh2 = ehc2;
        end
        pe = en; ps = sck; pe2 = en2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input bit chk_per, output frame_t r);
        int n = 0;
        while (q.size() == 0 && n < 400) begin @(negedge clk); n++; end
        chk("frame_timeout", 32'(q.size() > 0), 1);
        if (q.size() == 0) return;
        r = q.pop_front();
        chk("frame_byte", r.b, {r.f[3:0], r.dig[r.f[1:0]*4 +: 4]});
        chk("frame_rises", r.rises, 8);
        chk("frame_en_high", r.enhi, 34);
        if (chk_per) chk("frame_period", r.start - last_start, 98);
        last_start = r.start;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t r;
        int f_drop, nf_drop;
        repeat (3) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_spi_reset_n", spi_reset_n, 0);
        chk("rst_key_state", key_state, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst2_all", {srn2, sck2, mosi2, kv2, ks2}, 0);
        rst = 0; run = 1;
        @(negedge clk);
        chk("spi_reset_n_release", spi_reset_n, 1);
        chk("first_en", en, 1);
        chk("first_mosi", mosi, 0);
        // sweep 1: fixed digits, single pressed key
        check_frame(0, r);
        for (int i = 1; i < 16; i++) check_frame(1, r);
        for (int n = 0; n < 300 && kvn == 0; n++) @(negedge clk);
        chk("kv1_pulse", key_valid, 1);
        chk("kv1_count", kvn, 1);
        chk("key_state_sweep1", key_state, 16'h0200);
        pressed = 16'($urandom) | 16'h8001;
        digits = 16'($urandom);
        @(negedge clk);
        chk("kv_one_cycle", key_valid, 0);
        // sweep 2: random digits and keys
        for (int i = 0; i < 16; i++) check_frame(1, r);
        for (int n = 0; n < 300 && kvn == 1; n++) @(negedge clk);
        chk("kv2_count", kvn, 2);
        chk("key_state_sweep2", key_state, pressed);
        // drop run mid-shift
        for (int n = 0; n < 300 && !(en && fc == 5); n++) @(negedge clk);
        chk("drop_point", fc, 5);
        run = 0; nf_drop = nf; f_drop = (nf + 15) % 16;
        repeat (120) @(negedge clk);
        chk("idle_en", en, 0);
        chk("idle_sck", sck, 0);
        chk("idle_no_start", nf, nf_drop);
        chk("idle_key_hold", key_state, pressed);
        while (q.size() > 0) check_frame(1, r);
        chk("drop_frame_f", r.f, f_drop);
        run = 1;
        check_frame(0, r);
        chk("resume_f", r.f, (f_drop + 1) % 16);
        // digits change during frame f=0
        digits = 16'h4321;
        for (int n = 0; n < 3000 && !(en && fc == 3 && nf == 1); n++) @(negedge clk);
        chk("dig_change_point", nf, 1);
        digits = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            check_frame(1, r);
            if (r.f == 0) chk("dig_change_f0", r.b, 8'h01);
            if (r.f == 1) begin chk("dig_change_f1", r.b, 8'h1F); break; end
        end
        // reset during HOLD
        for (int n = 0; n < 300 && !(!en && hcy == 2); n++) @(negedge clk);
        chk("rst_point", hcy, 2);
        rst = 1;
        while (q.size() > 0) check_frame(1, r);
        @(negedge clk);
        chk("midrst_en", en, 0);
        chk("midrst_sck", sck, 0);
        chk("midrst_spi_reset_n", spi_reset_n, 0);
        chk("midrst_key_state", key_state, 0);
        @(negedge clk);
        digits = 16'h4321; rst = 0;
        check_frame(0, r);
        chk("restart_f", r.f, 0);
        chk("restart_byte", r.b, 8'h01);
        // minimum-parameter instance: period and sample window
        run2 = 1;
        for (int n = 0; n < 200 && st2 < 2; n++) @(negedge clk);
        chk("d2_period", per2, 21);
        chk("d2_en_high", eh2, 17);
        for (int n = 0; n < 200 && !(st2 == 3 && fc2 == 19); n++) @(negedge clk);
        miso2 = 0;
        for (int n = 0; n < 200 && st2 != 4; n++) @(negedge clk);
        miso2 = 1;
        for (int n = 0; n < 200 && !(st2 == 5 && fc2 == 16); n++) @(negedge clk);
        miso2 = 0;
        for (int n = 0; n < 200 && !(st2 == 6 && fc2 == 1); n++) @(negedge clk);
        miso2 = 1;
        @(negedge clk);
        chk("d2_sample_window", ks2, 16'h0010);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
